// File: rtl/poc_pkg.sv
// Shared definitions for the POC print path: printer_rx state encoding and default print time.
package poc_pkg;

    typedef enum logic [1:0] {
        ST_READY   = 2'd0,
        ST_PRINT   = 2'd1,
        ST_DELIVER = 2'd2
    } prx_state_t;

    localparam int PRINT_CYCLES_DEF = 4;

endpackage

// File: rtl/prx_print_timer.sv
// Loadable down-counter that times the PRINT phase of printer_rx; o_done is high at zero.
module prx_print_timer #(
    parameter int W = 3
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_done
);

    logic [W-1:0] count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_load_val;
        end else if (i_en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign o_done = (count == '0);

endmodule

// File: rtl/printer_rx.sv
// Printer side of the POC TR/PD/RDY handshake: captures a byte on a TR rising edge,
// holds RDY low for the print time, then hands the byte to a character sink.
module printer_rx
    import poc_pkg::*;
#(
    parameter int PRINT_CYCLES = PRINT_CYCLES_DEF,
    parameter int CNT_W        = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_tr,
    input  logic [7:0]       i_pd,
    output logic             o_rdy,
    output logic [7:0]       o_char,
    output logic             o_char_valid,
    input  logic             i_char_ready,
    output logic [CNT_W-1:0] o_char_count,
    output logic             o_overrun,
    input  logic             i_clr_err
);

    localparam int TW = (PRINT_CYCLES < 1) ? 1 : $clog2(PRINT_CYCLES + 1);
    localparam logic [TW-1:0] LOAD_VAL = TW'(PRINT_CYCLES - 1);

    generate
        if (PRINT_CYCLES < 1) begin : g_bad_print_cycles
            $error("printer_rx: PRINT_CYCLES must be at least 1");
        end
    endgenerate

    // state is the FSM observation point for bound checkers.
    prx_state_t       state;
    prx_state_t       state_d;
    logic             tr_q;
    logic             tr_rise;
    logic             accept;
    logic             timer_done;
    logic [7:0]       char_d;
    logic [CNT_W-1:0] count_d;
    logic             overrun_d;

    assign tr_rise = i_tr & ~tr_q;
    assign accept  = (state == ST_READY) & tr_rise;

    prx_print_timer #(
        .W (TW)
    ) u_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (accept),
        .i_load_val (LOAD_VAL),
        .i_en       (state == ST_PRINT),
        .o_done     (timer_done)
    );

    // Sink handshake: a character transfers on an edge where o_char_valid and
    // i_char_ready are both high; o_char and o_char_valid hold until that edge.
    always_comb begin
        state_d   = state;
        char_d    = o_char;
        count_d   = o_char_count;
        overrun_d = o_overrun;
        case (state)
            ST_READY: begin
                if (accept) begin
                    char_d  = i_pd;
                    state_d = ST_PRINT;
                end
            end
            ST_PRINT: begin
                if (timer_done) begin
                    state_d = ST_DELIVER;
                end
            end
            ST_DELIVER: begin
                if (i_char_ready) begin
                    count_d = o_char_count + 1'b1;
                    state_d = ST_READY;
                end
            end
            default: state_d = ST_READY;
        endcase
        // A new overrun in the same cycle as a clear keeps the flag set.
        if (tr_rise && (state != ST_READY)) begin
            overrun_d = 1'b1;
        end else if (i_clr_err) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= ST_READY;
            tr_q         <= 1'b1;
            o_rdy        <= 1'b1;
            o_char       <= '0;
            o_char_valid <= 1'b0;
            o_char_count <= '0;
            o_overrun    <= 1'b0;
        end else begin
            state        <= state_d;
            tr_q         <= i_tr;
            o_rdy        <= (state_d == ST_READY);
            o_char       <= char_d;
            o_char_valid <= (state_d == ST_DELIVER);
            o_char_count <= count_d;
            o_overrun    <= overrun_d;
        end
    end

endmodule

// File: tb/tb_printer_rx.sv
// Bench for printer_rx: directed handshake scenarios plus a randomized character stream.
module tb_printer_rx;

    localparam int PC = 4;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          tr;
    logic [7:0]    pd;
    logic          o_rdy;
    logic [7:0]    o_char;
    logic          o_char_valid;
    logic          i_char_ready;
    logic [CW-1:0] o_char_count;
    logic          o_overrun;
    logic          clr;

    int            total = 0;
    int            bad = 0;
    int            n_sent = 0;
    bit            exp_ovr = 1'b0;
    bit            rand_sink = 1'b0;
    logic [7:0]    exp_q[$];

    printer_rx #(
        .PRINT_CYCLES (PC),
        .CNT_W        (CW)
    ) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_tr         (tr),
        .i_pd         (pd),
        .o_rdy        (o_rdy),
        .o_char       (o_char),
        .o_char_valid (o_char_valid),
        .i_char_ready (i_char_ready),
        .o_char_count (o_char_count),
        .o_overrun    (o_overrun),
        .i_clr_err    (clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the edge after a negedge with valid & ready.
    always @(negedge clk) begin
        if (!rst && o_char_valid && i_char_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_char: got %0h want none", o_char);
            end else begin
                check("sink_char", {24'd0, o_char}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    // Random sink readiness when enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_sink) i_char_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rdy(input logic lvl, input string nm);
        int n = 0;
        while (o_rdy !== lvl && n < 300) begin
            step();
            n++;
        end
        if (o_rdy !== lvl) begin
            total++;
            bad++;
            $display("FAIL %s timeout: o_rdy=%b want %b", nm, o_rdy, lvl);
        end
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || o_rdy !== 1'b1) && n < 2000) begin
            step();
            n++;
        end
        check(nm, exp_q.size(), 0);
    endtask

    // POC-style send: TR stays high until one cycle after RDY comes back.
    task automatic poc_send(input logic [7:0] d);
        wait_rdy(1'b1, "poc_ready");
        tr = 1'b1;
        pd = d;
        exp_q.push_back(d);
        n_sent++;
        step();
        wait_rdy(1'b0, "poc_busy");
        wait_rdy(1'b1, "poc_done");
        step();
        tr = 1'b0;
        pd = 8'($urandom);
        step();
    endtask

    // Short-strobe send, optionally followed by a spurious TR edge while busy.
    task automatic pulse_send(input logic [7:0] d, input int hold, input bit inject);
        wait_rdy(1'b1, "pulse_ready");
        tr = 1'b1;
        pd = d;
        exp_q.push_back(d);
        n_sent++;
        repeat (hold) step();
        tr = 1'b0;
        pd = 8'($urandom);
        if (inject) begin
            step();
            tr = 1'b1;
            exp_ovr = 1'b1;
            step();
            tr = 1'b0;
        end
        step();
    endtask

    initial begin
        rst = 1'b1;
        tr = 1'b1;
        pd = 8'h00;
        clr = 1'b0;
        i_char_ready = 1'b1;
        repeat (3) step();
        rst = 1'b0;
        @(negedge clk);
        check("rst_rdy", o_rdy, 1);
        check("rst_valid", o_char_valid, 0);
        check("rst_char", o_char, 0);
        check("rst_count", o_char_count, 0);
        check("rst_overrun", o_overrun, 0);
        // TR already high at reset exit must not be accepted.
        repeat (3) @(negedge clk);
        check("tr_high_at_reset_ignored", o_rdy, 1);
        step();
        tr = 1'b0;
        repeat (3) step();

        // Single char with exact timing; TR held high across the RDY re-rise.
        tr = 1'b1;
        pd = 8'h41;
        exp_q.push_back(8'h41);
        n_sent++;
        @(posedge clk);
        @(negedge clk);
        check("t1_rdy_low", o_rdy, 0);
        for (int k = 1; k < PC; k++) begin
            @(negedge clk);
            check("t1_print_rdy", o_rdy, 0);
            check("t1_print_valid", o_char_valid, 0);
        end
        @(negedge clk);
        check("t1_valid", o_char_valid, 1);
        check("t1_char", o_char, 8'h41);
        check("t1_rdy_deliver", o_rdy, 0);
        @(negedge clk);
        check("t1_rdy_back", o_rdy, 1);
        check("t1_valid_drop", o_char_valid, 0);
        check("t1_count", o_char_count, 1);
        step();
        tr = 1'b0;
        repeat (4) step();
        check("t2_no_recapture_count", o_char_count, 1);
        check("t2_no_recapture_rdy", o_rdy, 1);
        check("t2_no_overrun", o_overrun, 0);

        // Sink backpressure.
        i_char_ready = 1'b0;
        pulse_send(8'h5A, 2, 1'b0);
        begin
            int n = 0;
            while (!o_char_valid && n < 50) begin
                step();
                n++;
            end
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_valid", o_char_valid, 1);
            check("bp_char", o_char, 8'h5A);
            check("bp_rdy", o_rdy, 0);
        end
        step();
        i_char_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("bp_rdy_after_ready", o_rdy, 1);
        check("bp_count", o_char_count, 2);

        // Overrun: spurious edge during PRINT is dropped and flagged.
        pulse_send(8'h33, 1, 1'b1);
        @(negedge clk);
        check("ovr_set", o_overrun, 1);
        wait_idle("ovr_drain");
        check("ovr_count", o_char_count, 3);
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;
        @(negedge clk);
        check("ovr_clear", o_overrun, 0);
        step();
        wait_rdy(1'b1, "ovr2_ready");
        tr = 1'b1;
        pd = 8'h34;
        exp_q.push_back(8'h34);
        n_sent++;
        step();
        tr = 1'b0;
        step();
        tr = 1'b1;
        pd = 8'h66;
        clr = 1'b1;
        step();
        tr = 1'b0;
        clr = 1'b0;
        @(negedge clk);
        check("ovr_set_beats_clr", o_overrun, 1);
        wait_idle("ovr2_drain");
        step();
        clr = 1'b1;
        step();
        clr = 1'b0;

        // Three-character stream driven like the POC.
        poc_send(8'h48);
        poc_send(8'h49);
        poc_send(8'h0A);
        wait_idle("stream_drain");
        check("stream_count", o_char_count, 7);
        check("stream_overrun", o_overrun, 0);

        // Reset during PRINT abandons the character.
        tr = 1'b1;
        pd = 8'h11;
        step();
        tr = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_sent = 0;
        @(negedge clk);
        check("midrst_rdy", o_rdy, 1);
        check("midrst_valid", o_char_valid, 0);
        check("midrst_count", o_char_count, 0);
        check("midrst_char", o_char, 0);
        repeat (2) step();
        pulse_send(8'h7E, 1, 1'b0);
        wait_idle("midrst_drain");
        check("midrst_count_after", o_char_count, 1);

        // Randomized stream with random sink stalls, strobe styles and overruns.
        rand_sink = 1'b1;
        exp_ovr = 1'b0;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if ($urandom_range(0, 2) == 0) begin
                poc_send(d);
            end else begin
                pulse_send(d, $urandom_range(1, 3), ($urandom_range(0, 4) == 0));
            end
            @(negedge clk);
            check("rnd_overrun", o_overrun, exp_ovr);
            step();
            if ($urandom_range(0, 1) == 1) begin
                clr = 1'b1;
                step();
                clr = 1'b0;
                exp_ovr = 1'b0;
            end
            repeat ($urandom_range(0, 5)) step();
        end
        wait_idle("rnd_drain");
        rand_sink = 1'b0;
        step();
        i_char_ready = 1'b1;
        check("rnd_count", o_char_count, n_sent);
        check("rnd_final_overrun", o_overrun, exp_ovr);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
